// File: rtl/id_operand_stage.sv
// id_operand_stage
// ----------------
// Decode-side operand stage. It takes the two register file read ports,
// resolves RAW hazards by forwarding from EX/MEM and MEM/WB, stalls when a
// producer's value does not exist yet, and owns the ID/EX pipeline register.
// Forwarding happens only here; EX consumes ex_op1/ex_op2 unmodified.
//
// Optional feature: define HAZARD_STATS_EN to add the stall_count and
// fwd_count saturating statistics outputs.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               discard the ID instruction (redirect)
//   id_*                decoded instruction fields from IF/ID
//   regd1, regd2        register file read data for id_rs / id_rt
//   exm_*               EX/MEM producer (we, is_load, dst, ALU result)
//   mwb_*               MEM/WB producer (we, dst, write-back data)
//   stall               combinational: hold PC and IF/ID this cycle
//   ex_*                ID/EX register contents
//   stall_count         (HAZARD_STATS_EN) edges with stall=1, saturating
//   fwd_count           (HAZARD_STATS_EN) loads with a forwarded operand
//
// Handshake: there is no valid/ready pair here. IF/ID presents an
// instruction with id_valid; when stall=1 the upstream must hold IF/ID and
// the PC so the same instruction is re-presented next cycle, while ID/EX
// receives a bubble. flush beats stall, and rst beats both.
module id_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [RADDR-1:0] id_dst,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic [WIDTH-1:0] regd1,
  input  logic [WIDTH-1:0] regd2,
  input  logic             exm_we,
  input  logic             exm_is_load,
  input  logic [RADDR-1:0] exm_dst,
  input  logic [WIDTH-1:0] exm_data,
  input  logic             mwb_we,
  input  logic [RADDR-1:0] mwb_dst,
  input  logic [WIDTH-1:0] mwb_data,
  output logic             stall,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_op1,
  output logic [WIDTH-1:0] ex_op2,
  output logic [RADDR-1:0] ex_dst,
  output logic             ex_we,
  output logic             ex_is_load
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      fwd_count
`endif
);

  // An operand is "live" only if it is used and not r0; a dead operand can
  // neither forward nor stall. Because a live index is never 0, a producer
  // with dst 0 can never match it.
  logic             rs_live, rt_live;
  logic             rs_exm, rs_mwb, rt_exm, rt_mwb;
  logic             rs_haz, rt_haz;
  logic [WIDTH-1:0] op1, op2;
  logic             load_en;

  always_comb begin
    rs_live = id_uses_rs && (id_rs != '0);
    rt_live = id_uses_rt && (id_rt != '0);

    // EX/MEM forwards ALU results only; a load there has no data yet.
    rs_exm = rs_live && exm_we && !exm_is_load && (exm_dst == id_rs);
    rt_exm = rt_live && exm_we && !exm_is_load && (exm_dst == id_rt);
    rs_mwb = rs_live && mwb_we && (mwb_dst == id_rs);
    rt_mwb = rt_live && mwb_we && (mwb_dst == id_rt);

    rs_haz = rs_live && ((ex_valid && ex_we && (ex_dst == id_rs)) ||
                         (exm_we && exm_is_load && (exm_dst == id_rs)));
    rt_haz = rt_live && ((ex_valid && ex_we && (ex_dst == id_rt)) ||
                         (exm_we && exm_is_load && (exm_dst == id_rt)));

    stall   = !rst && id_valid && !flush && (rs_haz || rt_haz);
    load_en = id_valid && !flush && !stall;

    // Unused operands pass the register file data straight through.
    op1 = regd1;
    if (id_uses_rs && (id_rs == '0)) op1 = '0;
    else if (rs_exm)                 op1 = exm_data;
    else if (rs_mwb)                 op1 = mwb_data;

    op2 = regd2;
    if (id_uses_rt && (id_rt == '0)) op2 = '0;
    else if (rt_exm)                 op2 = exm_data;
    else if (rt_mwb)                 op2 = mwb_data;
  end

  // ID/EX register. Bubbles clear only the control bits; data fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_we      <= 1'b0;
      ex_is_load <= 1'b0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_dst     <= '0;
    end else if (load_en) begin
      ex_valid   <= 1'b1;
      ex_we      <= id_we;
      ex_is_load <= id_is_load;
      ex_op1     <= op1;
      ex_op2     <= op2;
      ex_dst     <= id_dst;
    end else begin
      ex_valid   <= 1'b0;
      ex_we      <= 1'b0;
      ex_is_load <= 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
      if (load_en && (rs_exm || rs_mwb || rt_exm || rt_mwb) &&
          (fwd_count != '1))
        fwd_count <= fwd_count + 32'd1;
    end
  end
`endif

endmodule
